jtframe_colmix_fade: RTL and testbench

Parametrised palette/colour mixer, successor to the per-game fixed palette mixers. Selects the highest-priority opaque pixel among NL layer inputs and looks it up in an on-chip 16-bit palette written byte-wise by the CPU. Applies a frame-stepped global brightness fade, then aligns blanking and outputs RGB. Single clock domain: the CPU port and the pixel port share clk.

---
 rtl/jtframe_colmix_fade_if.sv | 25 ++
 rtl/jtframe_colmix_fade.sv | 196 +++++++++++++++++++
 tb/tb_jtframe_colmix_fade.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_colmix_fade_if.sv
`default_nettype none
// ============================================================================
// jtframe_colmix_fade_if : CPU palette bus (byte-wide, never stalled)
// Revision 1.0
// ============================================================================
interface jtframe_colmix_fade_if #(
   parameter int AW = 8
);
   logic          pal_cs;
   logic          cpu_rnw;
   logic [AW:0]   cpu_addr;
   logic [7:0]    cpu_dout;
   logic [7:0]    pal_dout;

   modport master (
      output pal_cs, cpu_rnw, cpu_addr, cpu_dout,
      input  pal_dout
   );

   modport slave (
      input  pal_cs, cpu_rnw, cpu_addr, cpu_dout,
      output pal_dout
   );
endinterface
`default_nettype wire

// File: rtl/jtframe_colmix_fade.sv
`default_nettype none
// ============================================================================
// jtframe_colmix_fade : layer priority, palette lookup, frame-stepped fade
// Revision 1.0
// ============================================================================
module jtframe_colmix_fade #(
   parameter int         AW     = 8,
   parameter int         CW     = 4,
   parameter int         NL     = 2,
   parameter logic [3:0] TRANSP = 4'hF,
   parameter int         FRATE  = 4
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              pxl_cen,
   input  wire logic              LHBL,
   input  wire logic              LVBL,
   output      logic              LHBL_dly,
   output      logic              LVBL_dly,
   input  wire logic [NL*AW-1:0]  lyr_idx,
   jtframe_colmix_fade_if.slave   cpu,
   input  wire logic              fade_start,
   input  wire logic              fade_dir,
   output      logic              fade_busy,
   output      logic [CW-1:0]     red,
   output      logic [CW-1:0]     green,
   output      logic [CW-1:0]     blue
);

   localparam logic [0:0] c_st_idle = 1'b0;
   localparam logic [0:0] c_st_run  = 1'b1;

   // Palette is split into byte lanes so each CPU write touches one lane only
   logic [7:0]    pal_lo [2**AW];
   logic [7:0]    pal_hi [2**AW];
   logic [15:0]   pix_q;

   logic [AW-1:0] sel_pri, sel_d, sel_q;
   logic [2:0]    hb_d, hb_q, vb_d, vb_q;
   logic [CW-1:0] red_d, red_q, green_d, green_q, blue_d, blue_q;
   logic [CW-1:0] red_raw, green_raw, blue_raw;
   logic [7:0]    pal_dout_d, pal_dout_q;

   logic [0:0]    state_d, state_q;
   logic [3:0]    lvl_d, lvl_q, fcnt_d, fcnt_q, fcnt_inc;
   logic          dir_d, dir_q;
   logic          lvbl_last_q, lvbl_fall, fade_done;

   function automatic logic [CW-1:0] scale(input logic [CW-1:0] c, input logic [3:0] l);
      logic [CW+4:0] p;
      p = {5'd0, c} * {{CW{1'b0}}, ({1'b0, l} + 5'd1)};
      return p[CW+3:4];
   endfunction

   // Palette RAM: the pixel read samples the array before this edge's write lands
   always_ff @(posedge clk) begin
      if (cpu.pal_cs && !cpu.cpu_rnw) begin
         if (cpu.cpu_addr[0]) pal_hi[cpu.cpu_addr[AW:1]] <= cpu.cpu_dout;
         else                 pal_lo[cpu.cpu_addr[AW:1]] <= cpu.cpu_dout;
      end
      if (pxl_cen) pix_q <= {pal_hi[sel_q], pal_lo[sel_q]};
   end

   always_comb begin
      pal_dout_d = pal_dout_q;
      if (cpu.cpu_rnw)
         pal_dout_d = cpu.cpu_addr[0] ? pal_hi[cpu.cpu_addr[AW:1]]
                                      : pal_lo[cpu.cpu_addr[AW:1]];
   end

   // Walk from the lowest priority up so the lowest opaque layer wins
   always_comb begin
      sel_pri = lyr_idx[(NL-1)*AW +: AW];
      for (int k = NL-1; k >= 0; k--) begin
         if (lyr_idx[k*AW +: 4] != TRANSP) sel_pri = lyr_idx[k*AW +: AW];
      end
   end

   generate
      if (CW == 4) begin : g_cw4
         logic unused_bits;
         assign red_raw     = pix_q[7:4];
         assign green_raw   = pix_q[3:0];
         assign blue_raw    = pix_q[15:12];
         assign unused_bits = ^pix_q[11:8];
      end else begin : g_cw5
         logic unused_bits;
         assign red_raw     = pix_q[4:0];
         assign green_raw   = pix_q[9:5];
         assign blue_raw    = pix_q[14:10];
         assign unused_bits = pix_q[15];
      end
   endgenerate

   always_comb begin
      sel_d   = sel_q;
      hb_d    = hb_q;
      vb_d    = vb_q;
      red_d   = red_q;
      green_d = green_q;
      blue_d  = blue_q;
      if (pxl_cen) begin
         sel_d = sel_pri;
         hb_d  = {hb_q[1:0], LHBL};
         vb_d  = {vb_q[1:0], LVBL};
         if (hb_q[1] && vb_q[1]) begin
            red_d   = scale(red_raw,   lvl_q);
            green_d = scale(green_raw, lvl_q);
            blue_d  = scale(blue_raw,  lvl_q);
         end else begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q      <= '0;
         hb_q       <= '0;
         vb_q       <= '0;
         red_q      <= '0;
         green_q    <= '0;
         blue_q     <= '0;
         pal_dout_q <= '0;
      end else begin
         sel_q      <= sel_d;
         hb_q       <= hb_d;
         vb_q       <= vb_d;
         red_q      <= red_d;
         green_q    <= green_d;
         blue_q     <= blue_d;
         pal_dout_q <= pal_dout_d;
      end
   end

   assign LHBL_dly     = hb_q[2];
   assign LVBL_dly     = vb_q[2];
   assign red          = red_q;
   assign green        = green_q;
   assign blue         = blue_q;
   assign cpu.pal_dout = pal_dout_q;

   // Fade FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= c_st_idle;
         lvl_q       <= 4'd15;
         fcnt_q      <= 4'd0;
         dir_q       <= 1'b0;
         lvbl_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lvl_q       <= lvl_d;
         fcnt_q      <= fcnt_d;
         dir_q       <= dir_d;
         lvbl_last_q <= LVBL;
      end
   end

   assign lvbl_fall = lvbl_last_q & ~LVBL;
   assign fade_done = dir_q ? (lvl_q == 4'd15) : (lvl_q == 4'd0);
   assign fcnt_inc  = fcnt_q + 4'd1;

   // Fade FSM: next state; a start always wins over a coincident frame edge
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      fcnt_d  = fcnt_q;
      dir_d   = dir_q;
      if (fade_start) begin
         state_d = c_st_run;
         dir_d   = fade_dir;
         fcnt_d  = 4'd0;
      end else if (state_q == c_st_run) begin
         if (fade_done) begin
            state_d = c_st_idle;
         end else if (lvbl_fall) begin
            if (fcnt_inc == 4'(FRATE)) begin
               fcnt_d = 4'd0;
               lvl_d  = dir_q ? lvl_q + 4'd1 : lvl_q - 4'd1;
            end else begin
               fcnt_d = fcnt_inc;
            end
         end
      end
   end

   // Fade FSM: outputs
   always_comb begin
      fade_busy = (state_q == c_st_run);
   end

endmodule
`default_nettype wire

// File: tb/tb_jtframe_colmix_fade.sv
`default_nettype none
// ============================================================================
// tb_jtframe_colmix_fade : directed vectors for priority, palette, fade
// Revision 1.0
// ============================================================================
module tb_jtframe_colmix_fade;
   localparam int AW = 8;
   localparam int CW = 4;
   localparam int NL = 2;

   logic clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b0;
   logic LHBL = 1'b1, LVBL = 1'b1, fade_start = 1'b0, fade_dir = 1'b0;
   logic [NL*AW-1:0] lyr_idx = '0;
   logic LHBL_dly, LVBL_dly, fade_busy;
   logic [CW-1:0] red, green, blue;
   int n_tests = 0, n_fail = 0;

   jtframe_colmix_fade_if #(.AW(AW)) cpu_bus ();

   jtframe_colmix_fade #(
      .AW(AW), .CW(CW), .NL(NL), .TRANSP(4'hF), .FRATE(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
      .LHBL(LHBL), .LVBL(LVBL), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
      .lyr_idx(lyr_idx), .cpu(cpu_bus),
      .fade_start(fade_start), .fade_dir(fade_dir), .fade_busy(fade_busy),
      .red(red), .green(green), .blue(blue)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_pxl(input int n);
      repeat (n) begin
         @(negedge clk); pxl_cen = 1'b1;
         @(negedge clk); pxl_cen = 1'b0;
      end
   endtask

   task automatic cpu_wr(input logic [8:0] addr, input logic [7:0] data);
      @(negedge clk);
      cpu_bus.pal_cs = 1'b1; cpu_bus.cpu_rnw = 1'b0;
      cpu_bus.cpu_addr = addr; cpu_bus.cpu_dout = data;
      @(negedge clk);
      cpu_bus.pal_cs = 1'b0; cpu_bus.cpu_rnw = 1'b1;
   endtask

   task automatic cpu_rd(input string tag, input logic [8:0] addr, input logic [7:0] exp);
      @(negedge clk);
      cpu_bus.pal_cs = 1'b0; cpu_bus.cpu_rnw = 1'b1; cpu_bus.cpu_addr = addr;
      @(negedge clk);
      check_val(tag, 32'(cpu_bus.pal_dout), 32'(exp));
   endtask

   task automatic set_lyr(input logic [7:0] l0, input logic [7:0] l1);
      lyr_idx = {l1, l0};
   endtask

   task automatic frame();
      @(negedge clk); LVBL = 1'b0;
      @(negedge clk); LVBL = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start(input logic dir);
      @(negedge clk); fade_start = 1'b1; fade_dir = dir;
      @(negedge clk); fade_start = 1'b0;
   endtask

   task automatic check_rgb(input string tag, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
      check_val({tag, "_r"}, 32'(red),   32'(r));
      check_val({tag, "_g"}, 32'(green), 32'(g));
      check_val({tag, "_b"}, 32'(blue),  32'(b));
   endtask

   initial begin
      cpu_bus.pal_cs = 1'b0; cpu_bus.cpu_rnw = 1'b1;
      cpu_bus.cpu_addr = '0; cpu_bus.cpu_dout = '0;
      repeat (3) @(negedge clk);
      check_rgb("rst", 4'h0, 4'h0, 4'h0);
      check_val("rst_lhbl_dly", 32'(LHBL_dly), 32'd0);
      check_val("rst_lvbl_dly", 32'(LVBL_dly), 32'd0);
      check_val("rst_pal_dout", 32'(cpu_bus.pal_dout), 32'd0);
      check_val("rst_busy", 32'(fade_busy), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // Basic lookup: entry 0x12 = 0x70A5
      cpu_wr(9'h024, 8'hA5);
      cpu_wr(9'h025, 8'h70);
      set_lyr(8'h12, 8'hFF);
      wait_pxl(3);
      check_rgb("basic", 4'hA, 4'h5, 4'h7);
      check_val("lhbl_dly_on", 32'(LHBL_dly), 32'd1);

      // Blanking lags by exactly three pixel stages
      LHBL = 1'b0;
      wait_pxl(2);
      check_val("lhbl_dly_2", 32'(LHBL_dly), 32'd1);
      check_val("blank_2_r", 32'(red), 32'hA);
      wait_pxl(1);
      check_val("lhbl_dly_3", 32'(LHBL_dly), 32'd0);
      check_val("blank_3_r", 32'(red), 32'h0);
      LHBL = 1'b1;
      wait_pxl(3);
      check_val("unblank_dly", 32'(LHBL_dly), 32'd1);
      check_val("unblank_r", 32'(red), 32'hA);

      // Priority
      cpu_wr(9'h040, 8'h00); cpu_wr(9'h041, 8'h0F);
      set_lyr(8'h3F, 8'h20);
      wait_pxl(3);
      check_rgb("pri_l1", 4'h0, 4'h0, 4'h0);
      cpu_wr(9'h042, 8'h36); cpu_wr(9'h043, 8'h9C);
      set_lyr(8'h4F, 8'h21);
      wait_pxl(3);
      check_rgb("pri_l1b", 4'h3, 4'h6, 4'h9);
      cpu_wr(9'h062, 8'hF0); cpu_wr(9'h063, 8'h00);
      set_lyr(8'h31, 8'h21);
      wait_pxl(3);
      check_rgb("pri_l0", 4'hF, 4'h0, 4'h0);
      cpu_wr(9'h03E, 8'h00); cpu_wr(9'h03F, 8'h30);
      set_lyr(8'h5F, 8'h1F);
      wait_pxl(3);
      check_rgb("pri_all_tr", 4'h0, 4'h0, 4'h3);

      // CPU readback
      cpu_wr(9'h025, 8'h5A);
      cpu_rd("rd_hi", 9'h025, 8'h5A);
      cpu_rd("rd_lo", 9'h024, 8'hA5);
      cpu_rd("rd_pal21_hi", 9'h043, 8'h9C);

      // Collision: CPU write lands on the same edge as the S2 read
      set_lyr(8'h21, 8'hFF);
      wait_pxl(3);
      check_val("coll_pre_r", 32'(red), 32'h3);
      @(negedge clk);
      pxl_cen = 1'b1;
      cpu_bus.pal_cs = 1'b1; cpu_bus.cpu_rnw = 1'b0;
      cpu_bus.cpu_addr = 9'h042; cpu_bus.cpu_dout = 8'h5B;
      @(negedge clk);
      pxl_cen = 1'b0;
      cpu_bus.pal_cs = 1'b0; cpu_bus.cpu_rnw = 1'b1;
      wait_pxl(1);
      check_rgb("coll_old", 4'h3, 4'h6, 4'h9);
      wait_pxl(1);
      check_rgb("coll_new", 4'h5, 4'hB, 4'h9);

      // Fade out then in, FRATE=1
      set_lyr(8'h31, 8'hFF);
      wait_pxl(3);
      check_val("fade_pre_r", 32'(red), 32'hF);
      pulse_start(1'b0);
      check_val("fade_out_busy", 32'(fade_busy), 32'd1);
      repeat (8) frame();
      wait_pxl(1);
      check_val("fade_out_8_r", 32'(red), 32'h7);
      check_val("fade_out_8_busy", 32'(fade_busy), 32'd1);
      repeat (7) frame();
      wait_pxl(1);
      check_val("fade_out_15_r", 32'(red), 32'h0);
      check_val("fade_out_done", 32'(fade_busy), 32'd0);
      pulse_start(1'b1);
      repeat (8) frame();
      wait_pxl(1);
      check_val("fade_in_8_r", 32'(red), 32'h8);
      repeat (7) frame();
      wait_pxl(1);
      check_val("fade_in_15_r", 32'(red), 32'hF);
      check_val("fade_in_done", 32'(fade_busy), 32'd0);

      // Start at target: RUN for one clk only
      @(negedge clk); fade_start = 1'b1; fade_dir = 1'b1;
      @(negedge clk); fade_start = 1'b0;
      check_val("target_busy_hi", 32'(fade_busy), 32'd1);
      @(negedge clk);
      check_val("target_busy_lo", 32'(fade_busy), 32'd0);
      wait_pxl(1);
      check_val("target_r", 32'(red), 32'hF);

      // Start coinciding with a frame edge takes no step
      @(negedge clk); fade_start = 1'b1; fade_dir = 1'b0; LVBL = 1'b0;
      @(negedge clk); fade_start = 1'b0; LVBL = 1'b1;
      wait_pxl(1);
      check_val("coinc_r", 32'(red), 32'hF);
      check_val("coinc_busy", 32'(fade_busy), 32'd1);
      repeat (9) frame();
      wait_pxl(1);
      check_val("lvl6_r", 32'(red), 32'h6);

      // Reset mid-fade
      @(negedge clk); rst_n = 1'b0;
      #1;
      check_rgb("midrst", 4'h0, 4'h0, 4'h0);
      check_val("midrst_busy", 32'(fade_busy), 32'd0);
      check_val("midrst_lhbl", 32'(LHBL_dly), 32'd0);
      @(negedge clk); rst_n = 1'b1;
      wait_pxl(3);
      check_val("postrst_r", 32'(red), 32'hF);
      check_val("postrst_busy", 32'(fade_busy), 32'd0);
      check_val("postrst_lhbl", 32'(LHBL_dly), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
